// File: rtl/umi_pkg.sv
// Shared UMI constants for the register host: opcodes, cmd field offsets,
// completion codes and the FSM state encoding.
package umi_pkg;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] RESP_WRITE = 5'h04;
    localparam logic [4:0] REQ_POSTED = 5'h05;

    localparam int CMD_OP_LSB   = 0;
    localparam int CMD_SIZE_LSB = 5;
    localparam int CMD_LEN_LSB  = 8;
    localparam int CMD_ERR_LSB  = 25;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_PROTO   = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [4:0] resp_opcode(input logic is_read);
        return is_read ? RESP_READ : RESP_WRITE;
    endfunction

endpackage

// File: rtl/umi_reghost_if.sv
// UMI host port bundle: request channel out of the host, response channel back in.
interface umi_reghost_if #(
    parameter int AW = 64,
    parameter int CW = 32,
    parameter int DW = 256
);
    logic          req_valid;
    logic [CW-1:0] req_cmd;
    logic [AW-1:0] req_dstaddr;
    logic [AW-1:0] req_srcaddr;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          resp_valid;
    logic [CW-1:0] resp_cmd;
    logic [AW-1:0] resp_dstaddr;
    logic [AW-1:0] resp_srcaddr;
    logic [DW-1:0] resp_data;
    logic          resp_ready;

    modport master (
        output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
        input  req_ready,
        input  resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
        output req_ready,
        output resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/umi_pack.sv
// Builds a UMI command word from opcode, size and len; every other field is zero.
module umi_pack
    import umi_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [4:0]    opcode,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    output logic [CW-1:0] cmd
);
    always_comb begin
        cmd = '0;
        cmd[CMD_OP_LSB +: 5]   = opcode;
        cmd[CMD_SIZE_LSB +: 3] = size;
        cmd[CMD_LEN_LSB +: 8]  = len;
    end
endmodule

// File: rtl/umi_unpack.sv
// Extracts the fields the register host needs from a UMI response command.
module umi_unpack
    import umi_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [CW-1:0] cmd,
    output logic [4:0]    opcode,
    output logic [1:0]    err
);
    logic unused_cmd;

    assign opcode     = cmd[CMD_OP_LSB +: 5];
    assign err        = cmd[CMD_ERR_LSB +: 2];
    assign unused_cmd = ^{cmd[CW-1:CMD_ERR_LSB+2], cmd[CMD_ERR_LSB-1:CMD_OP_LSB+5]};
endmodule

// File: rtl/umi_reghost.sv
// Register-to-UMI host bridge: one register request becomes one UMI request,
// completed by its matching response. Define UMI_REGHOST_TIMEOUT_EN for the abort timer.
module umi_reghost
    import umi_pkg::*;
#(
    parameter int            AW       = 64,
    parameter int            CW       = 32,
    parameter int            DW       = 256,
    parameter int            RW       = 64,
    parameter logic [AW-1:0] HOSTADDR = '0,
    parameter int            TOW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_read,
    input  logic          reg_write,
    input  logic          reg_posted,
    input  logic [AW-1:0] reg_addr,
    input  logic [2:0]    reg_size,
    input  logic [7:0]    reg_len,
    input  logic [RW-1:0] reg_wrdata,
    output logic          reg_ready,
    output logic          reg_done,
    output logic [RW-1:0] reg_rddata,
    output logic [1:0]    reg_err,
    umi_reghost_if.master uhost
);
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          accept;
    logic          req_fire;
    logic          resp_fire;
    logic          abort;
    logic          to_expire;
    logic          done_q;
    logic [1:0]    err_q;
    logic [RW-1:0] rddata_q;
    logic [CW-1:0] cmd_q;
    logic [CW-1:0] cmd_nx;
    logic [AW-1:0] dst_q;
    logic [DW-1:0] data_q;
    logic          is_read_q;
    logic          posted_q;
    logic          resp_ready_q;
    logic [4:0]    req_op;
    logic [4:0]    resp_op;
    logic [1:0]    resp_err;
    logic          resp_match;
    logic          unused_resp;

    // Read wins when both strobes are high; the write is silently dropped.
    assign req_op = reg_read   ? REQ_READ   :
                    reg_posted ? REQ_POSTED : REQ_WRITE;

    umi_pack #(.CW(CW)) u_pack (
        .opcode (req_op),
        .size   (reg_size),
        .len    (reg_len),
        .cmd    (cmd_nx)
    );

    umi_unpack #(.CW(CW)) u_unpack (
        .cmd    (uhost.resp_cmd),
        .opcode (resp_op),
        .err    (resp_err)
    );

    assign resp_match = (resp_op == resp_opcode(is_read_q)) &&
                        (uhost.resp_dstaddr == HOSTADDR);
    assign unused_resp = ^{uhost.resp_srcaddr, uhost.resp_data};

    // Holding reg_ready low through the done cycle keeps completion and the
    // next accept in separate cycles.
    assign reg_ready         = (state == ST_IDLE) && !done_q;
    assign reg_done          = done_q;
    assign reg_rddata        = rddata_q;
    assign reg_err           = err_q;
    assign uhost.req_valid   = (state == ST_REQ);
    assign uhost.req_cmd     = cmd_q;
    assign uhost.req_dstaddr = dst_q;
    assign uhost.req_srcaddr = HOSTADDR;
    assign uhost.req_data    = data_q;
    assign uhost.resp_ready  = resp_ready_q;

`ifdef UMI_REGHOST_TIMEOUT_EN
    logic [TOW-1:0] to_cnt;

    assign to_expire = &to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if ((state_nx != state) || (state == ST_IDLE)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    localparam int unused_tow = TOW;

    assign to_expire = 1'b0;
`endif

    // A handshake always takes priority over an expiry in the same cycle.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        req_fire  = 1'b0;
        resp_fire = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reg_ready && (reg_read || reg_write)) begin
                    accept   = 1'b1;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (uhost.req_ready) begin
                    req_fire = 1'b1;
                    state_nx = posted_q ? ST_IDLE : ST_RESP;
                end else if (to_expire) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (uhost.resp_valid) begin
                    resp_fire = 1'b1;
                    state_nx  = ST_IDLE;
                end else if (to_expire) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            done_q       <= 1'b0;
            err_q        <= ERR_OK;
            rddata_q     <= '0;
            cmd_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            is_read_q    <= 1'b0;
            posted_q     <= 1'b0;
            resp_ready_q <= 1'b0;
        end else begin
            state        <= state_nx;
            resp_ready_q <= (state_nx != ST_REQ);
            done_q       <= 1'b0;
            if (accept) begin
                cmd_q     <= cmd_nx;
                dst_q     <= reg_addr;
                data_q    <= reg_read ? '0 : DW'(reg_wrdata);
                is_read_q <= reg_read;
                posted_q  <= !reg_read && reg_posted;
            end
            if (req_fire && posted_q) begin
                done_q <= 1'b1;
                err_q  <= ERR_OK;
            end
            if (abort) begin
                done_q <= 1'b1;
                err_q  <= ERR_TIMEOUT;
            end
            if (resp_fire) begin
                done_q <= 1'b1;
                err_q  <= resp_match ? resp_err : ERR_PROTO;
                if (resp_match && is_read_q) begin
                    rddata_q <= uhost.resp_data[RW-1:0];
                end
            end
        end
    end
endmodule

// File: doc/umi_reghost.md
Name: umi_reghost

Overview:
- Register-to-UMI initiator. It turns one simple register read/write request into one UMI host request packet.
- It waits for the matching UMI response and returns read data or completion status to the register side.
- It sits on a UMI host port, opposite the device-side register bridge, so local logic or firmware can reach remote UMI register spaces.
- Exactly one transaction is outstanding at a time.

Parameters:
- AW, 64, UMI address width
- CW, 32, UMI command width
- DW, 256, UMI data width
- RW, 64, register data width (RW <= DW)
- HOSTADDR, 0, value driven on uhost_req_srcaddr; used as the response return address
- TOW, 16, timeout counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- reg_read  in  1  start read; sampled only when reg_ready=1
- reg_write  in  1  start write; sampled only when reg_ready=1
- reg_posted  in  1  with reg_write: issue a posted write (no response expected)
- reg_addr  in  AW  target address
- reg_size  in  3  UMI size field
- reg_len  in  8  UMI len field
- reg_wrdata  in  RW  write data
- reg_ready  out  1  idle, can accept a request
- reg_done  out  1  one-cycle pulse when a transaction completes
- reg_rddata  out  RW  read data; valid with reg_done and held until the next accept
- reg_err  out  2  completion error code; valid with reg_done
- uhost_req_valid  out  1
- uhost_req_cmd  out  CW
- uhost_req_dstaddr  out  AW
- uhost_req_srcaddr  out  AW
- uhost_req_data  out  DW
- uhost_req_ready  in  1
- uhost_resp_valid  in  1
- uhost_resp_cmd  in  CW
- uhost_resp_dstaddr  in  AW
- uhost_resp_srcaddr  in  AW
- uhost_resp_data  in  DW
- uhost_resp_ready  out  1

Behaviour:
- Reset values: reg_ready=1, reg_done=0, reg_rddata=0, reg_err=0, uhost_req_valid=0, uhost_req_cmd/dstaddr/data=0, uhost_resp_ready=0.
- Reset is asynchronous and may be asserted mid-transaction. It forces IDLE immediately and drops any in-flight packet. A late response arriving after reset is accepted and discarded in IDLE.
- FSM states: IDLE, REQ, RESP.

IDLE:
- reg_ready=1 and uhost_resp_ready=1; stray responses are drained and ignored.
- On reg_read|reg_write: register addr, cmd and data, then go to REQ. reg_ready falls the next cycle.
- If reg_read and reg_write are both high, read wins; the write is dropped and not flagged.
- Opcode selection: read -> REQ_READ (0x01); write -> REQ_WRITE (0x03); write with reg_posted -> REQ_POSTED (0x05).
- All other cmd fields are zero apart from size and len.
- uhost_req_data = zero-extended wrdata. Read requests carry zero data.

REQ:
- uhost_req_valid=1; all req outputs stay stable until the handshake.
- On uhost_req_valid & uhost_req_ready: if posted, pulse reg_done with err=0 and return to IDLE; otherwise go to RESP.
- Minimum latency from accept to reg_done is 2 cycles for posted, 3 cycles for non-posted.

RESP:
- uhost_resp_ready=1. A response is accepted on uhost_resp_valid.
- Expected response opcode: RESP_READ (0x02) for reads, RESP_WRITE (0x04) for writes.
- If the opcode matches and dstaddr==HOSTADDR:
  - reg_err = response err field.
  - For reads, reg_rddata = resp_data[RW-1:0].
- If the opcode does not match or dstaddr!=HOSTADDR: reg_err=2'b11 and reg_rddata is unchanged.
- Either way, pulse reg_done and go to IDLE. reg_ready returns the cycle after reg_done.
- A response with uhost_resp_valid already high on the cycle of RESP entry is accepted in that cycle.

Optional Feature:
- Macro: UMI_REGHOST_TIMEOUT_EN.
- Enabled:
  - A TOW-bit counter clears on entry to REQ and RESP and increments each cycle in those states.
  - On all-ones without a handshake, it aborts to IDLE with reg_done=1 and reg_err=2'b10; uhost_req_valid drops.
  - A handshake in the same cycle as expiry wins.
- Disabled: no counter, and the block waits indefinitely.

Decomposition:
- Shared package umi_pkg holds:
  - opcode constants (REQ_READ, REQ_WRITE, REQ_POSTED, RESP_READ, RESP_WRITE)
  - cmd field offsets
  - reg_err codes: OK=0, TIMEOUT=2, PROTO=3
  - FSM state encoding
- Request command assembly uses the existing umi_pack sub-module; response decode uses umi_unpack. No new sub-module.

Test Plan:
- Read addr 0x1000, resp_cmd 0x02 with data 0xDEADBEEF after 5 cycles -> req_cmd opcode 0x01, srcaddr=HOSTADDR; reg_done pulse, rddata=0xDEADBEEF, err=0.
- Write 0x55 to 0x2000, uhost_req_ready low for 4 cycles -> req outputs stable throughout; write response gives reg_done with err=0.
- Posted write -> opcode 0x05; reg_done 1 cycle after req handshake; stray response in IDLE is consumed and ignored.
- Read answered with opcode 0x04 -> reg_err=3 and rddata retains its previous value.
- Timeout enabled with TOW=4, no response -> reg_done with err=2 sixteen cycles after RESP entry; next read then completes normally.
- reset asserted in RESP -> reg_ready=1 and req_valid=0 immediately; the late response is drained with no reg_done.
